// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad row scanner.
//   scan_state_t : scanner FSM states
//   key_code_t   : {row_idx[1:0], col_idx[1:0]}
//   ROW_IDLE     : row drive pattern for row 0 (active-low one-hot)
package keypad_pkg;

  typedef enum logic [1:0] {DRIVE, SAMPLE, HOLD, RELEASE} scan_state_t;
  typedef logic [3:0] key_code_t;

  localparam logic [3:0] ROW_IDLE = 4'b1110;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Lowest-indexed active-low column wins (col0 has highest priority).
  function automatic logic [1:0] lowest_zero(input logic [3:0] col);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Row idx drive pattern: ROW_IDLE rotated left by idx.
  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    logic [7:0] dbl;
    dbl = {ROW_IDLE, ROW_IDLE} << idx;
    return dbl[7:4];
  endfunction

endpackage

// File: rtl/keypad_row_scanner_if.sv
// Keypad scanner signal bundle.
//   master : scanner side (drives rows and key report, reads columns)
//   slave  : keypad/consumer side
//   col_in    4  debounced columns, active-low
//   row_out   4  row drive, one-hot active-low
//   key_code  4  {row_idx, col_idx} of last detected key
//   key_valid 1  one-cycle strike for a new (or repeated) key_code
//   key_held  1  detected key still pressed
interface keypad_row_scanner_if;
  import keypad_pkg::*;

  logic [3:0] col_in;
  logic [3:0] row_out;
  key_code_t  key_code;
  logic       key_valid;
  logic       key_held;

  modport master (input col_in, output row_out, key_code, key_valid, key_held);
  modport slave  (output col_in, input row_out, key_code, key_valid, key_held);

endinterface

// File: rtl/keypad_dwell_timer.sv
// Up-counter with synchronous clear/enable and terminal-count flag.
//   clk, reset : clock, async active-low reset
//   clr        : clear to 0 (wins over en)
//   en         : count up by one
//   term       : terminal count value
//   tc         : count currently equals term
module keypad_dwell_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) cnt_d = '0;
    else if (en) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == term);

endmodule

// File: rtl/keypad_row_scanner.sv
// 4x4 matrix keypad row scanner: drives one row low at a time, samples the
// debounced columns once per row after a settle time, and reports the first
// pressed key as a one-cycle key_valid strike with its code.
//   clk, reset : clock, async active-low reset
//   kif        : keypad_row_scanner_if.master (col_in, row_out, key_code,
//                key_valid, key_held)
// Build option KEYPAD_REPEAT_EN: while a key stays in HOLD, re-strike
// key_valid every REPEAT_CYC cycles.
//
// state   | meaning
// DRIVE   | row driven, waiting SETTLE_CYC cycles for columns to settle
// SAMPLE  | columns evaluated once, then idle until the row time ends
// HOLD    | key reported, row frozen, waiting for all columns high
// RELEASE | counting consecutive all-high cycles before declaring release
module keypad_row_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_PER_ROW = 50000,
  parameter int SETTLE_CYC  = 16,
  parameter int RELEASE_CYC = 1000,
  parameter int REPEAT_CYC  = 250000
) (
  input logic                  clk,
  input logic                  reset,
  keypad_row_scanner_if.master kif
);

  localparam int CNT_W = $clog2(max_of(max_of(CLK_PER_ROW, SETTLE_CYC),
                                       max_of(RELEASE_CYC, REPEAT_CYC))) + 1;

  scan_state_t state_q, state_d;
  logic [1:0]  row_q, row_d;
  key_code_t   code_q, code_d;
  logic        valid_q, valid_d;
  logic        fresh_q, fresh_d;

  logic             col_idle, detect;
  logic             dwell_clr, dwell_tc, rel_clr, rel_en, rel_tc;
  logic [CNT_W-1:0] dwell_term;

  assign col_idle = (kif.col_in == 4'hF);
  // Columns are looked at only on the first SAMPLE cycle of each row.
  assign detect   = (state_q == SAMPLE) && fresh_q && !col_idle;

  // One dwell counter spans DRIVE and SAMPLE; its terminal value switches
  // from the settle point to the end of the row time.
  assign dwell_term = (state_q == DRIVE) ? CNT_W'(SETTLE_CYC - 1) : CNT_W'(CLK_PER_ROW - 1);
  assign dwell_clr  = (state_q == HOLD) || (state_q == RELEASE) ||
                      ((state_q == SAMPLE) && (detect || dwell_tc));

  assign rel_clr = (state_q != RELEASE);
  assign rel_en  = (state_q == RELEASE) && col_idle;

  keypad_dwell_timer #(.WIDTH(CNT_W)) u_dwell (
    .clk(clk), .reset(reset), .clr(dwell_clr), .en(1'b1),
    .term(dwell_term), .tc(dwell_tc)
  );

  keypad_dwell_timer #(.WIDTH(CNT_W)) u_release (
    .clk(clk), .reset(reset), .clr(rel_clr), .en(rel_en),
    .term(CNT_W'(RELEASE_CYC - 1)), .tc(rel_tc)
  );

`ifdef KEYPAD_REPEAT_EN
  logic rpt_tc;
  // Not cleared by a RELEASE->HOLD bounce: the period keeps running.
  keypad_dwell_timer #(.WIDTH(CNT_W)) u_repeat (
    .clk(clk), .reset(reset),
    .clr(detect || ((state_q == HOLD) && rpt_tc)),
    .en(state_q == HOLD),
    .term(CNT_W'(REPEAT_CYC - 1)), .tc(rpt_tc)
  );
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    code_d  = code_q;
    valid_d = 1'b0;
    fresh_d = (state_q == DRIVE) && dwell_tc;
    case (state_q)
      DRIVE: begin
        if (dwell_tc) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (detect) begin
          code_d  = {row_q, lowest_zero(kif.col_in)};
          valid_d = 1'b1;
          state_d = HOLD;
        end else if (dwell_tc) begin
          row_d   = row_q + 2'd1;
          state_d = DRIVE;
        end
      end
      HOLD: begin
        if (col_idle) state_d = RELEASE;
      end
      RELEASE: begin
        if (!col_idle) begin
          state_d = HOLD;
        end else if (rel_tc) begin
          row_d   = row_q + 2'd1;
          state_d = DRIVE;
        end
      end
      default: state_d = DRIVE;
    endcase
`ifdef KEYPAD_REPEAT_EN
    if ((state_q == HOLD) && rpt_tc) valid_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DRIVE;
      row_q   <= 2'd0;
      code_q  <= '0;
      valid_q <= 1'b0;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      fresh_q <= fresh_d;
    end
  end

  assign kif.row_out   = row_drive(row_q);
  assign kif.key_code  = code_q;
  assign kif.key_valid = valid_q;
  assign kif.key_held  = (state_q == HOLD) || (state_q == RELEASE);

endmodule

// File: tb/tb_keypad_row_scanner.sv
// Self-checking bench for keypad_row_scanner (CLK_PER_ROW=8, SETTLE_CYC=2,
// RELEASE_CYC=4, REPEAT_CYC=20). A cycle-level behavioural model of the
// scanning rules is compared against the DUT on every falling edge, and
// directed scenarios add hand-computed expectations.
module tb_keypad_row_scanner;

  localparam int CPR    = 8;
  localparam int SETTLE = 2;
  localparam int REL    = 4;
  localparam int RPT    = 20;
`ifdef KEYPAD_REPEAT_EN
  localparam int EXP_PULSES = 4;
`else
  localparam int EXP_PULSES = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;

  keypad_row_scanner_if kif();

  keypad_row_scanner #(
    .CLK_PER_ROW(CPR), .SETTLE_CYC(SETTLE), .RELEASE_CYC(REL), .REPEAT_CYC(RPT)
  ) dut (
    .clk(clk), .reset(reset), .kif(kif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // m_age  : cycles since the current row started being driven
  // m_run  : consecutive all-high column samples while a key is held
  // m_rpt  : cycles spent waiting in the held-and-pressed condition
  int         m_row = 0, m_age = 0, m_run = 0, m_rpt = 0;
  bit         m_held = 0, m_valid = 0;
  logic [3:0] m_code = 4'h0;

  function automatic logic [1:0] first_pressed(input logic [3:0] c);
    for (int i = 0; i < 4; i++) if (!c[i]) return 2'(i);
    return 2'd0;
  endfunction

  function automatic logic [3:0] row_pattern(input int r);
    return 4'hF ^ (4'h1 << r);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_row = 0; m_age = 0; m_run = 0; m_rpt = 0;
      m_held = 0; m_valid = 0; m_code = 4'h0;
    end else begin
      m_valid = 0;
      if (!m_held) begin
        if (m_age == SETTLE && kif.col_in != 4'hF) begin
          m_code  = {m_row[1:0], first_pressed(kif.col_in)};
          m_held  = 1; m_valid = 1;
          m_run   = 0; m_rpt = 0; m_age = 0;
        end else if (m_age == CPR - 1) begin
          m_row = (m_row + 1) % 4;
          m_age = 0;
        end else begin
          m_age++;
        end
      end else begin
`ifdef KEYPAD_REPEAT_EN
        if (m_run == 0) begin
          if (m_rpt == RPT - 1) begin m_valid = 1; m_rpt = 0; end
          else m_rpt++;
        end
`endif
        if (kif.col_in == 4'hF) begin
          m_run++;
          // first all-high sample plus REL further ones declares release
          if (m_run == REL + 1) begin
            m_held = 0; m_run = 0; m_age = 0;
            m_row = (m_row + 1) % 4;
          end
        end else begin
          m_run = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("cyc_row_out",   32'(kif.row_out),   32'(row_pattern(m_row)));
      check("cyc_key_code",  32'(kif.key_code),  32'(m_code));
      check("cyc_key_valid", 32'(kif.key_valid), 32'(m_valid));
      check("cyc_key_held",  32'(kif.key_held),  32'(m_held));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_row(input string name, input logic [3:0] target);
    for (int i = 0; i < 48; i++) begin
      if (kif.row_out == target) break;
      @(negedge clk);
    end
    check(name, 32'(kif.row_out), 32'(target));
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (kif.key_valid) begin lat = i; break; end
    end
  endtask

  task automatic wait_release(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!kif.key_held) break;
    end
    check(name, 32'(kif.key_held), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int nv, lat;
    int t_valid[8];
    foreach (t_valid[j]) t_valid[j] = 0;
    kif.col_in = 4'hF;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_row_out",   32'(kif.row_out),   32'h0000000E);
    check("rst_key_code",  32'(kif.key_code),  32'h0);
    check("rst_key_valid", 32'(kif.key_valid), 32'h0);
    check("rst_key_held",  32'(kif.key_held),  32'h0);
    reset = 1'b1;

    // 1: no key, rows rotate every 8 clocks
    nv = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (kif.key_valid) nv++;
      if (k == 4)  check("t1_row_k4",  32'(kif.row_out), 32'h0000000E);
      if (k == 12) check("t1_row_k12", 32'(kif.row_out), 32'h0000000D);
      if (k == 20) check("t1_row_k20", 32'(kif.row_out), 32'h0000000B);
      if (k == 28) check("t1_row_k28", 32'(kif.row_out), 32'h00000007);
      if (k == 36) check("t1_row_k36", 32'(kif.row_out), 32'h0000000E);
    end
    check("t1_valid_count", 32'(nv), 32'd0);

    // 2: single key in row 1, column 2
    wait_row("t2_reach_row1", 4'b1101);
    kif.col_in = 4'b1011;
    wait_valid(lat);
    check("t2_latency",  32'(lat), 32'd3);
    check("t2_key_code", 32'(kif.key_code), 32'h6);
    check("t2_key_held", 32'(kif.key_held), 32'd1);
    nv = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (kif.key_valid) nv++;
    end
    check("t2_extra_valid", 32'(nv), 32'd0);
    check("t2_row_frozen",  32'(kif.row_out), 32'h0000000D);

    // 3: release with one bounce
    kif.col_in = 4'hF;
    @(negedge clk); kif.col_in = 4'hB;
    @(negedge clk); kif.col_in = 4'hF;
    nv = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (kif.key_valid) nv++;
    end
    check("t3_held_before", 32'(kif.key_held), 32'd1);
    @(negedge clk);
    if (kif.key_valid) nv++;
    check("t3_held_after", 32'(kif.key_held), 32'd0);
    check("t3_row_next",   32'(kif.row_out), 32'h0000000B);
    check("t3_no_valid",   32'(nv), 32'd0);

    // 4: two keys in row 3, column 1 wins over column 3
    wait_row("t4_reach_row3", 4'b0111);
    kif.col_in = 4'b0101;
    wait_valid(lat);
    check("t4_latency",  32'(lat), 32'd3);
    check("t4_key_code", 32'(kif.key_code), 32'hD);
    kif.col_in = 4'hF;
    wait_release("t4_release");
    check("t4_row_wrap", 32'(kif.row_out), 32'h0000000E);

    // 5: asynchronous reset while a key is held
    wait_row("t5_reach_row2", 4'b1011);
    kif.col_in = 4'b0111;
    wait_valid(lat);
    check("t5_key_code", 32'(kif.key_code), 32'hB);
    @(negedge clk);
    check("t5_held_pre", 32'(kif.key_held), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t5_async_row",   32'(kif.row_out),   32'h0000000E);
    check("t5_async_code",  32'(kif.key_code),  32'h0);
    check("t5_async_valid", 32'(kif.key_valid), 32'h0);
    check("t5_async_held",  32'(kif.key_held),  32'h0);
    kif.col_in = 4'hF;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 4) check("t5_restart_row0", 32'(kif.row_out), 32'h0000000E);
      if (k == 8) check("t5_restart_row1", 32'(kif.row_out), 32'h0000000D);
    end

    // 6: key held 70 clocks
    wait_row("t6_reach_row1", 4'b1101);
    kif.col_in = 4'b1110;
    nv = 0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (kif.key_valid) begin
        if (nv < 8) t_valid[nv] = k;
        nv++;
      end
    end
    check("t6_pulse_count", 32'(nv), 32'(EXP_PULSES));
    check("t6_first_pulse", 32'(t_valid[0]), 32'd3);
    check("t6_key_code",    32'(kif.key_code), 32'h4);
`ifdef KEYPAD_REPEAT_EN
    for (int j = 1; j < 4; j++)
      check("t6_repeat_spacing", 32'(t_valid[j] - t_valid[j-1]), 32'd20);
`endif
    kif.col_in = 4'hF;
    wait_release("t6_release");
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
